// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA raster timing generator with test-pattern source
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_PULSE   = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_PULSE   = 2,
   parameter int V_BACK    = 33,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int CB        = 2,
   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_PULSE + H_BACK,
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_PULSE + V_BACK,
   localparam int XW       = $clog2(H_TOTAL),
   localparam int YW       = $clog2(V_TOTAL),
   localparam int BAR_W    = H_VISIBLE / 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [1:0]    mode,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [CB-1:0] vga_r,
   output logic [CB-1:0] vga_g,
   output logic [CB-1:0] vga_b
);

   localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] H_VIS_C  = XW'(H_VISIBLE);
   localparam logic [XW-1:0] HS_START = XW'(H_VISIBLE + H_FRONT);
   localparam logic [XW:0]   HS_END   = (XW+1)'(H_VISIBLE + H_FRONT + H_PULSE);
   localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);
   localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] V_VIS_C  = YW'(V_VISIBLE);
   localparam logic [YW-1:0] VS_START = YW'(V_VISIBLE + V_FRONT);
   localparam logic [YW:0]   VS_END   = (YW+1)'(V_VISIBLE + V_FRONT + V_PULSE);
   localparam logic          HS_LVL   = HSYNC_POL[0];
   localparam logic          VS_LVL   = VSYNC_POL[0];

   logic [XW-1:0] hc;
   logic [YW-1:0] vc;
   logic [1:0]    mode_q;
   logic [7:0]    frame_cnt;
   logic [XW-1:0] bar_px;
   logic [2:0]    bar_idx;

   logic          h_wrap;
   logic          v_wrap;
   logic          at_origin;
   logic          hs_act;
   logic          vs_act;
   logic          vis;
   logic [1:0]    cur_mode;
   logic [CB-1:0] hc_sh;
   logic [CB-1:0] vc_sh;
   logic [CB-1:0] pat_r;
   logic [CB-1:0] pat_g;
   logic [CB-1:0] pat_b;

   assign h_wrap    = (hc == H_LAST);
   assign v_wrap    = (vc == V_LAST);
   assign at_origin = (hc == '0) && (vc == '0);
   assign hs_act    = (hc >= HS_START) && ({1'b0, hc} < HS_END);
   assign vs_act    = (vc >= VS_START) && ({1'b0, vc} < VS_END);
   assign vis       = (hc < H_VIS_C) && (vc < V_VIS_C);
   // The frame-start pixel already uses the mode being latched, so a new frame is uniform.
   assign cur_mode  = at_origin ? mode : mode_q;
   // Zero-extended so narrow rasters still yield defined upper counter bits.
   assign hc_sh     = CB'({{(CB+6){1'b0}}, hc} >> 5);
   assign vc_sh     = CB'({{(CB+6){1'b0}}, vc} >> 5);

   always_comb begin
      pat_r = '0;
      pat_g = '0;
      pat_b = '0;
      case (cur_mode)
         2'd0: pat_b = '1;
         2'd1: begin
            pat_r = {CB{bar_idx[2]}};
            pat_g = {CB{bar_idx[1]}};
            pat_b = {CB{bar_idx[0]}};
         end
         2'd2: begin
            pat_r = {CB{hc_sh[0] ^ vc_sh[0]}};
            pat_g = {CB{hc_sh[0] ^ vc_sh[0]}};
            pat_b = {CB{hc_sh[0] ^ vc_sh[0]}};
         end
         default: begin
            pat_r = frame_cnt[7 -: CB];
            pat_g = vc_sh;
            pat_b = hc_sh;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hc        <= '0;
         vc        <= '0;
         mode_q    <= 2'd0;
         frame_cnt <= 8'd0;
         bar_px    <= '0;
         bar_idx   <= 3'd0;
      end else if (en) begin
         if (at_origin) begin
            mode_q <= mode;
         end
         if (h_wrap) begin
            hc      <= '0;
            bar_px  <= '0;
            bar_idx <= 3'd0;
            if (v_wrap) begin
               vc        <= '0;
               frame_cnt <= frame_cnt + 8'd1;
            end else begin
               vc <= vc + YW'(1);
            end
         end else begin
            hc <= hc + XW'(1);
            // Bar index saturates so any remainder pixels stay in the last bar.
            if (bar_px == BAR_LAST) begin
               bar_px <= '0;
               if (bar_idx != 3'd7) begin
                  bar_idx <= bar_idx + 3'd1;
               end
            end else begin
               bar_px <= bar_px + XW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync       <= ~HS_LVL;
         vsync       <= ~VS_LVL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else begin
         hsync       <= (en && hs_act) ? HS_LVL : ~HS_LVL;
         vsync       <= (en && vs_act) ? VS_LVL : ~VS_LVL;
         de          <= en && vis;
         x           <= hc;
         y           <= vc;
         line_start  <= en && (hc == '0);
         frame_start <= en && at_origin;
         vga_r       <= (en && vis) ? pat_r : '0;
         vga_g       <= (en && vis) ? pat_g : '0;
         vga_b       <= (en && vis) ? pat_b : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// Bench for vga_timing_gen: default-timing instance plus two reduced rasters
// checked cycle-by-cycle against a positional reference model.
module tb_vga_timing_gen;

   typedef struct {
      int hv, hf, hp, hb, vv, vf, vp, vb, hpol, vpol, cb;
   } cfg_t;
   typedef struct {
      int hc, vc, fc, md;
   } st_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;

   logic       hs0, vs0, de0, ls0, fs0;
   logic [9:0] x0, y0;
   logic [1:0] r0, g0, b0;

   logic       hs1, vs1, de1, ls1, fs1;
   logic [6:0] x1, y1;
   logic [1:0] r1, g1, b1;

   logic       hs2, vs2, de2, ls2, fs2;
   logic [4:0] x2;
   logic [3:0] y2;
   logic [3:0] r2, g2, b2;

   logic [48:0] act1, act2;
   logic [48:0] q1[$];
   logic [48:0] q2[$];
   cfg_t C1, C2;
   st_t  m1, m2;
   int   n_total, n_bad, cyc;

   vga_timing_gen u_d0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
      .line_start(ls0), .frame_start(fs0), .vga_r(r0), .vga_g(g0), .vga_b(b0)
   );

   vga_timing_gen #(
      .H_VISIBLE(84), .H_FRONT(4), .H_PULSE(8), .H_BACK(4),
      .V_VISIBLE(64), .V_FRONT(2), .V_PULSE(3), .V_BACK(3)
   ) u_d1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
      .line_start(ls1), .frame_start(fs1), .vga_r(r1), .vga_g(g1), .vga_b(b1)
   );

   vga_timing_gen #(
      .H_VISIBLE(16), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
      .V_VISIBLE(8), .V_FRONT(1), .V_PULSE(2), .V_BACK(1),
      .HSYNC_POL(1), .VSYNC_POL(1), .CB(4)
   ) u_d2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .hsync(hs2), .vsync(vs2), .de(de2), .x(x2), .y(y2),
      .line_start(ls2), .frame_start(fs2), .vga_r(r2), .vga_g(g2), .vga_b(b2)
   );

   assign act1 = {hs1, vs1, de1, ls1, fs1, 16'(x1), 16'(y1), 4'(r1), 4'(g1), 4'(b1)};
   assign act2 = {hs2, vs2, de2, ls2, fs2, 16'(x2), 16'(y2), r2, g2, b2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: outputs for the raster position held in s, derived positionally.
   function automatic logic [48:0] expect_out(input cfg_t c, input st_t s,
                                              input logic r_i, input logic e_i,
                                              input logic [1:0] md_i);
      logic hp, vp, hs, vs, dv, ls, fs;
      int   mask, md, bar, cr, cg, cbv;
      hp   = c.hpol[0];
      vp   = c.vpol[0];
      mask = (1 << c.cb) - 1;
      cr = 0; cg = 0; cbv = 0;
      if (r_i) return {~hp, ~vp, 3'b000, 32'd0, 12'd0};
      if (!e_i) return {~hp, ~vp, 3'b000, 16'(s.hc), 16'(s.vc), 12'd0};
      hs = (s.hc >= c.hv + c.hf && s.hc < c.hv + c.hf + c.hp) ? hp : ~hp;
      vs = (s.vc >= c.vv + c.vf && s.vc < c.vv + c.vf + c.vp) ? vp : ~vp;
      dv = (s.hc < c.hv) && (s.vc < c.vv);
      ls = (s.hc == 0);
      fs = ls && (s.vc == 0);
      md = fs ? int'(md_i) : s.md;
      if (dv) begin
         case (md)
            0: cbv = mask;
            1: begin
               bar = s.hc / (c.hv / 8);
               if (bar > 7) bar = 7;
               cr  = ((bar >> 2) & 1) != 0 ? mask : 0;
               cg  = ((bar >> 1) & 1) != 0 ? mask : 0;
               cbv = (bar & 1) != 0 ? mask : 0;
            end
            2: begin
               bar = ((s.hc >> 5) ^ (s.vc >> 5)) & 1;
               cr  = (bar != 0) ? mask : 0;
               cg  = cr;
               cbv = cr;
            end
            default: begin
               cr  = (s.fc >> (8 - c.cb)) & mask;
               cg  = (s.vc >> 5) & mask;
               cbv = (s.hc >> 5) & mask;
            end
         endcase
      end
      return {hs, vs, dv, ls, fs, 16'(s.hc), 16'(s.vc), 4'(cr), 4'(cg), 4'(cbv)};
   endfunction

   function automatic st_t next_st(input cfg_t c, input st_t s, input logic r_i,
                                   input logic e_i, input logic [1:0] md_i);
      st_t n;
      n = s;
      if (r_i) begin
         n.hc = 0; n.vc = 0; n.fc = 0; n.md = 0;
      end else if (e_i) begin
         if (s.hc == 0 && s.vc == 0) n.md = int'(md_i);
         n.hc = s.hc + 1;
         if (n.hc == c.hv + c.hf + c.hp + c.hb) begin
            n.hc = 0;
            n.vc = s.vc + 1;
            if (n.vc == c.vv + c.vf + c.vp + c.vb) begin
               n.vc = 0;
               n.fc = (s.fc + 1) % 256;
            end
         end
      end
      return n;
   endfunction

   // One clock: push expectations for the inputs now applied, then pop and score.
   task automatic step();
      logic [48:0] e;
      q1.push_back(expect_out(C1, m1, rst, en, mode));
      q2.push_back(expect_out(C2, m2, rst, en, mode));
      m1 = next_st(C1, m1, rst, en, mode);
      m2 = next_st(C2, m2, rst, en, mode);
      @(posedge clk);
      #1;
      cyc++;
      e = q1.pop_front();
      if (n_bad < 40) begin
         n_total++;
         if (act1 !== e) begin
            n_bad++;
            $display("FAIL sb_d1 cyc=%0d act=%h exp=%h", cyc, act1, e);
         end
      end
      e = q2.pop_front();
      if (n_bad < 40) begin
         n_total++;
         if (act2 !== e) begin
            n_bad++;
            $display("FAIL sb_d2 cyc=%0d act=%h exp=%h", cyc, act2, e);
         end
      end
   endtask

   task automatic seek(input int tx, input int ty, input int lim);
      int i;
      i = 0;
      do begin
         step();
         i++;
      end while (!(int'(x1) == tx && int'(y1) == ty) && i < lim);
      if (!(int'(x1) == tx && int'(y1) == ty)) begin
         n_total++;
         n_bad++;
         $display("FAIL seek_timeout act=%0d,%0d exp=%0d,%0d", x1, y1, tx, ty);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mode = 2'd0;
      step();
      step();
      n_total++;
      if ({hs1, vs1, hs0, vs0} !== 4'b1111) begin
         n_bad++; $display("FAIL rst_sync_low act=%b exp=1111", {hs1, vs1, hs0, vs0});
      end
      n_total++;
      if ({hs2, vs2} !== 2'b00) begin
         n_bad++; $display("FAIL rst_sync_high act=%b exp=00", {hs2, vs2});
      end
      n_total++;
      if ({de1, ls1, fs1, x1, y1, r1, g1, b1} !== 23'd0) begin
         n_bad++; $display("FAIL rst_outputs act=%h exp=0", {de1, ls1, fs1, x1, y1, r1, g1, b1});
      end
      rst = 1'b0; en = 1'b1;
      step();
      n_total++;
      if (x1 !== 7'd0 || y1 !== 7'd0 || {de1, ls1, fs1} !== 3'b111) begin
         n_bad++; $display("FAIL first_pixel act=x%0d y%0d flags%b exp=x0 y0 flags111", x1, y1, {de1, ls1, fs1});
      end
      n_total++;
      if ({r1, g1, b1} !== 6'b000011) begin
         n_bad++; $display("FAIL first_colour act=%b exp=000011", {r1, g1, b1});
      end
   endtask

   task automatic test_default_line();
      int ls_t[$];
      int hs_low, hs_first, de_cnt, col_bad;
      hs_low = 0; hs_first = -1; de_cnt = 0; col_bad = 0;
      for (int i = 0; i < 1700; i++) begin
         step();
         if (ls0) ls_t.push_back(cyc);
         if (y0 == 10'd1) begin
            if (!hs0) begin
               hs_low++;
               if (hs_first < 0) hs_first = int'(x0);
            end
            if (de0) de_cnt++;
         end
         if (de0 ? ({r0, g0, b0} !== 6'b000011) : ({r0, g0, b0} !== 6'd0)) col_bad++;
      end
      n_total++;
      if (ls_t.size() < 2 || ls_t[1] - ls_t[0] != 800) begin
         n_bad++; $display("FAIL line_period act=%0d exp=800", ls_t.size() < 2 ? -1 : ls_t[1] - ls_t[0]);
      end
      n_total++;
      if (hs_low != 96 || hs_first != 656) begin
         n_bad++; $display("FAIL hsync_pulse act=%0d@%0d exp=96@656", hs_low, hs_first);
      end
      n_total++;
      if (de_cnt != 640) begin
         n_bad++; $display("FAIL de_per_line act=%0d exp=640", de_cnt);
      end
      n_total++;
      if (col_bad != 0) begin
         n_bad++; $display("FAIL solid_colour act=%0d bad pixels exp=0", col_bad);
      end
   endtask

   task automatic test_frame_timing();
      int f0, f1, dec, vmin, vmax, vcnt;
      f0 = -1; f1 = -1; dec = 0; vmin = 9999; vmax = -1; vcnt = 0;
      for (int i = 0; i < 16000 && f1 < 0; i++) begin
         step();
         if (fs1) begin
            if (f0 < 0) f0 = cyc;
            else f1 = cyc;
         end
         if (f0 >= 0 && f1 < 0) begin
            if (de1) dec++;
            if (!vs1) begin
               vcnt++;
               if (int'(y1) < vmin) vmin = int'(y1);
               if (int'(y1) > vmax) vmax = int'(y1);
            end
         end
      end
      n_total++;
      if (f1 < 0 || f1 - f0 != 7200) begin
         n_bad++; $display("FAIL frame_period act=%0d exp=7200", f1 - f0);
      end
      n_total++;
      if (dec != 5376) begin
         n_bad++; $display("FAIL de_per_frame act=%0d exp=5376", dec);
      end
      n_total++;
      if (vmin != 66 || vmax != 68 || vcnt != 300) begin
         n_bad++; $display("FAIL vsync_lines act=%0d..%0d n%0d exp=66..68 n300", vmin, vmax, vcnt);
      end
   endtask

   task automatic test_pol_cb4();
      int k, lastr, lastchg, chg, gap_bad, hs_hi, vs_hi, w;
      k = 0; lastr = -1; lastchg = -1; chg = 0; gap_bad = 0; hs_hi = 0; vs_hi = 0; w = 0;
      mode = 2'd3;
      do begin step(); w++; end while (!fs2 && w < 400);
      for (int i = 0; i < 34 * 288; i++) begin
         if (fs2) begin
            n_total++;
            if (r2 !== 4'(m2.fc >> 4)) begin
               n_bad++; $display("FAIL gradient_r frame=%0d act=%0d exp=%0d", k, r2, m2.fc >> 4);
            end
            if (int'(r2) != lastr) begin
               if (lastr >= 0) begin
                  if (lastchg >= 0 && k - lastchg != 16) gap_bad++;
                  lastchg = k;
                  chg++;
               end
               lastr = int'(r2);
            end
            k++;
         end
         if (hs2) hs_hi++;
         if (vs2) vs_hi++;
         step();
      end
      n_total++;
      if (k != 34 || chg < 2 || gap_bad != 0) begin
         n_bad++; $display("FAIL r_step_16 act=frames%0d chg%0d badgap%0d exp=34/>=2/0", k, chg, gap_bad);
      end
      n_total++;
      if (hs_hi != 1224 || vs_hi != 1632) begin
         n_bad++; $display("FAIL pos_sync_count act=%0d/%0d exp=1224/1632", hs_hi, vs_hi);
      end
   endtask

   task automatic test_bars();
      logic [5:0] exp;
      logic       chk;
      mode = 2'd1;
      seek(0, 0, 8000);
      for (int i = 0; i < 120; i++) begin
         chk = 1'b1;
         exp = 6'd0;
         case (int'(x1))
            0, 9:       exp = 6'b000000;
            10:         exp = 6'b000011;
            45:         exp = 6'b110000;
            79, 80, 83: exp = 6'b111111;
            default:    chk = 1'b0;
         endcase
         if (chk && y1 <= 7'd1) begin
            n_total++;
            if ({r1, g1, b1} !== exp) begin
               n_bad++; $display("FAIL bars x=%0d y=%0d act=%b exp=%b", x1, y1, {r1, g1, b1}, exp);
            end
         end
         step();
      end
   endtask

   task automatic test_mode_change();
      mode = 2'd0;
      seek(0, 0, 8000);
      seek(0, 10, 2000);
      mode = 2'd2;
      seek(32, 20, 2000);
      n_total++;
      if ({r1, g1, b1} !== 6'b000011) begin
         n_bad++; $display("FAIL no_tearing act=%b exp=000011", {r1, g1, b1});
      end
      seek(32, 0, 8000);
      n_total++;
      if ({r1, g1, b1} !== 6'b111111) begin
         n_bad++; $display("FAIL checker_32_0 act=%b exp=111111", {r1, g1, b1});
      end
      seek(32, 32, 5000);
      n_total++;
      if ({r1, g1, b1} !== 6'b000000) begin
         n_bad++; $display("FAIL checker_32_32 act=%b exp=000000", {r1, g1, b1});
      end
   endtask

   task automatic test_en_gap();
      int t0, idle_bad;
      idle_bad = 0;
      seek(0, 0, 8000);
      t0 = cyc;
      seek(29, 20, 8000);
      en = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (hs1 !== 1'b1 || vs1 !== 1'b1 || de1 !== 1'b0 || ls1 !== 1'b0 || fs1 !== 1'b0 ||
             {r1, g1, b1} !== 6'd0 || hs2 !== 1'b0 || vs2 !== 1'b0 || de2 !== 1'b0 ||
             ls2 !== 1'b0 || fs2 !== 1'b0) idle_bad++;
      end
      n_total++;
      if (idle_bad != 0) begin
         n_bad++; $display("FAIL idle_outputs act=%0d busy cycles exp=0", idle_bad);
      end
      en = 1'b1;
      step();
      n_total++;
      if (x1 !== 7'd30 || y1 !== 7'd20) begin
         n_bad++; $display("FAIL resume_pos act=%0d,%0d exp=30,20", x1, y1);
      end
      seek(0, 0, 8000);
      n_total++;
      if (cyc - t0 != 7250) begin
         n_bad++; $display("FAIL stretched_frame act=%0d exp=7250", cyc - t0);
      end
   endtask

   task automatic test_reset_mid();
      seek(70, 30, 8000);
      rst = 1'b1;
      step();
      n_total++;
      if (x1 !== 7'd0 || y1 !== 7'd0 || {hs1, vs1, de1, ls1, fs1} !== 5'b11000 || hs2 !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset act=x%0d y%0d flags%b exp=x0 y0 flags11000", x1, y1, {hs1, vs1, de1, ls1, fs1});
      end
      rst = 1'b0;
      mode = 2'd3;
      step();
      n_total++;
      if (x1 !== 7'd0 || y1 !== 7'd0 || fs1 !== 1'b1) begin
         n_bad++; $display("FAIL restart act=x%0d y%0d fs%b exp=x0 y0 fs1", x1, y1, fs1);
      end
      n_total++;
      if (r1 !== 2'd0 || r2 !== 4'd0) begin
         n_bad++; $display("FAIL frame_cnt_cleared act=%0d/%0d exp=0/0", r1, r2);
      end
      for (int i = 0; i < 300; i++) step();
   endtask

   initial begin
      n_total = 0; n_bad = 0; cyc = 0;
      C1 = '{84, 4, 8, 4, 64, 2, 3, 3, 0, 0, 2};
      C2 = '{16, 2, 3, 3, 8, 1, 2, 1, 1, 1, 4};
      m1 = '{0, 0, 0, 0};
      m2 = '{0, 0, 0, 0};
      rst = 1'b1; en = 1'b0; mode = 2'd0;
      test_reset();
      test_default_line();
      test_frame_timing();
      test_pol_cb4();
      test_bars();
      test_mode_change();
      test_en_gap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
